decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the immediate and PC width; only 32 and 64 are legal.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; reset is asynchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1, which discards all buffered entries.
REQ-005 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_instr (input, 32, raw RV32I word) and in_pc (input, XLEN).
REQ-006 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_pc (output, XLEN).
REQ-007 The block SHALL have decoded-field outputs out_opcode (7), out_funct3 (3), out_funct7 (7), out_rd (5), out_rs1 (5), out_rs2 (5), out_imm (XLEN), out_type (3) and out_illegal (1).

Function
REQ-008 The block SHALL be a decode pipeline stage with a 2-entry skid buffer, implemented as an FSM with states EMPTY, HOLD (1 entry) and FULL (2 entries).
- Transfer in: in_valid && in_ready.
- Transfer out: out_valid && out_ready.
REQ-009 in_ready SHALL be a registered signal, equal to (state != FULL).
- out_valid SHALL equal (state != EMPTY).
REQ-010 FSM transitions SHALL be as follows; otherwise the state holds.
- EMPTY to HOLD on transfer in.
- HOLD to FULL on transfer in without transfer out.
- HOLD to EMPTY on transfer out without transfer in.
- FULL to HOLD on transfer out.
REQ-011 Latency SHALL be 1 cycle: a word accepted at edge N is presented with out_valid=1 after edge N.
- Full throughput of one word per cycle when out_ready=1.
REQ-012 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
- Output order SHALL equal acceptance order.
REQ-013 The raw fields SHALL be taken from bit slices of in_instr, regardless of type.
- opcode from [6:0], rd from [11:7], funct3 from [14:12], rs1 from [19:15], rs2 from [24:20], funct7 from [31:25].
REQ-014 out_type SHALL be assigned by opcode.
- R=0: 0110011.
- I=1: 0010011, 0000011, 1100111, 1110011.
- S=2: 0100011.
- B=3: 1100011.
- U=4: 0110111, 0010111.
- J=5: 1101111.
- Any other opcode: 7.
REQ-015 out_imm SHALL be sign-extended to XLEN from instr[31].
- R-type and type 7: zero.
- I-type: instr[31:20].
- S-type: {instr[31:25], instr[11:7]}.
- B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U-type: {instr[31:12], 12 zeros}.
- J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-016 out_pc SHALL pass through the accepted in_pc unchanged.
REQ-017 A flush SHALL force state EMPTY at the next edge.
- Any same-cycle transfer in is dropped; in_ready=1 afterwards.
REQ-018 When flush coincides with a transfer out, the outgoing word SHALL count as delivered, and the state SHALL still be EMPTY.

Reset
REQ-019 While rst_n=0, the block SHALL immediately (asynchronously) set state EMPTY, in_ready=0, out_valid=0 and all out_* data to zero.
REQ-020 in_ready SHALL rise on the first edge after rst_n deasserts.
REQ-021 Assertion of rst_n=0 mid-transfer SHALL discard all entries with no partial output.

Configuration
REQ-022 With macro DECODE_ILLEGAL_CHECK_EN defined, out_illegal SHALL be 1 for any of the following conditions:
- instr[1:0] != 11.
- out_type=7.
- An R-type word with funct7 not in {0000000, 0100000}.
- in_instr == 0.
REQ-023 Without DECODE_ILLEGAL_CHECK_EN, out_illegal SHALL be tied to 0 and no check logic SHALL be synthesised; out_type=7 still marks unknown opcodes.

Verification
REQ-024 add x1,x2,x3 (0x003100B3), out_ready=1 -> next cycle out_valid=1, opcode=0110011, rd=1, rs1=2, rs2=3, funct7=0, type=0, imm=0.
REQ-025 addi x1,x2,-1 (0xFFF10093) -> type=1, imm=0xFFFFFFFF.
- beq x2,x3,-4 (0xFE310EE3) -> type=3, imm=0xFFFFFFFC.
REQ-026 XLEN=64, lui x1,0x80000 (0x800000B7) -> type=4, imm=0xFFFFFFFF80000000.
REQ-027 out_ready=0, three back-to-back words A,B,C offered:
- A and B are accepted; in_ready=0 and C stalls; outputs hold A.
- out_ready=1 -> outputs A, B, C in order, one per cycle.
REQ-028 State FULL, then flush=1 together with in_valid=1 -> out_valid=0 the next cycle, the input word is never output, and in_ready=1.
REQ-029 in_instr=0x00000000, and separately 0x0000007F, are each decoded with the result depending on the macro:
- With DECODE_ILLEGAL_CHECK_EN: out_illegal=1.
- Without it: out_illegal=0 and type=7.
- rst_n pulsed low mid-stream -> out_valid drops immediately, with no stale output after release.

Source files
------------

// File: rtl/decode_stage_if.sv
// Decode stage bus: upstream valid/ready word+PC in, decoded fields out.
// master = producer/consumer side (bench or neighbouring stages), slave = decode_stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_type, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage with a 2-entry skid buffer (EMPTY/HOLD/FULL).
// Words are decoded on acceptance and stored decoded; the head entry drives
// the outputs directly, so all out_* are registered and hold while stalled.
// XLEN must be 32 or 64.
// Optional: define DECODE_ILLEGAL_CHECK_EN to generate out_illegal; otherwise
// out_illegal is tied low and no check logic exists.
module decode_stage #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  decode_stage_if.slave bus
);

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_X = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      typ;
    logic            illegal;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, HOLD, FULL} state_t;

  state_t             state, state_nxt;
  logic               in_rdy_q;
  logic               xfer_in, xfer_out;
  logic [31:0]        ins;
  logic signed [31:0] imm32;
  dec_t               dec, head, tail;

  assign ins           = bus.in_instr;
  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = (state != EMPTY);
  assign xfer_in       = bus.in_valid && in_rdy_q;
  assign xfer_out      = bus.out_valid && bus.out_ready;

  // combinational decode of the incoming word
  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.pc     = bus.in_pc;
    dec.opcode = ins[6:0];
    dec.rd     = ins[11:7];
    dec.funct3 = ins[14:12];
    dec.rs1    = ins[19:15];
    dec.rs2    = ins[24:20];
    dec.funct7 = ins[31:25];
    case (ins[6:0])
      7'b0110011:                                     dec.typ = T_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec.typ = T_I;
      7'b0100011:                                     dec.typ = T_S;
      7'b1100011:                                     dec.typ = T_B;
      7'b0110111, 7'b0010111:                         dec.typ = T_U;
      7'b1101111:                                     dec.typ = T_J;
      default:                                        dec.typ = T_X;
    endcase
    case (dec.typ)
      T_I:     imm32 = {{20{ins[31]}}, ins[31:20]};
      T_S:     imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      T_B:     imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      T_U:     imm32 = {ins[31:12], 12'b0};
      T_J:     imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // signed cast widens from bit 31, which is instr[31] for every non-zero immediate
    dec.imm = XLEN'(imm32);
`ifdef DECODE_ILLEGAL_CHECK_EN
    dec.illegal = (ins[1:0] != 2'b11) || (dec.typ == T_X) || (ins == 32'd0) ||
                  ((dec.typ == T_R) && (ins[31:25] != 7'b0000000) &&
                   (ins[31:25] != 7'b0100000));
`else
    dec.illegal = 1'b0;
`endif
  end

  // state register; in_ready is registered straight from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_rdy_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_rdy_q <= (state_nxt != FULL);
    end
  end

  // next-state; flush overrides everything and drops any same-cycle input
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (xfer_in) state_nxt = HOLD;
      HOLD: begin
        if (xfer_in && !xfer_out)      state_nxt = FULL;
        else if (xfer_out && !xfer_in) state_nxt = EMPTY;
      end
      FULL:    if (xfer_out) state_nxt = HOLD;
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end

  // entry storage: head feeds the outputs, tail is the skid slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (!flush) begin
      case (state)
        EMPTY: if (xfer_in) head <= dec;
        HOLD: begin
          if (xfer_in && xfer_out) head <= dec;
          else if (xfer_in)        tail <= dec;
        end
        FULL:    if (xfer_out) head <= tail;
        default: ;
      endcase
    end
  end

  assign bus.out_pc      = head.pc;
  assign bus.out_imm     = head.imm;
  assign bus.out_opcode  = head.opcode;
  assign bus.out_funct3  = head.funct3;
  assign bus.out_funct7  = head.funct7;
  assign bus.out_rd      = head.rd;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_type    = head.typ;
  assign bus.out_illegal = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a 32-bit and a 64-bit instance share
// stimulus; the driver pushes expected decodes on acceptance, the monitor
// pops and compares on every delivered word.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] pc64 = '0;

  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage_if #(.XLEN(64)) bus64 ();

  decode_stage #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  decode_stage #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));

  assign bus.in_pc       = pc64[31:0];
  assign bus64.in_pc     = pc64;
  assign bus64.in_valid  = bus.in_valid;
  assign bus64.in_instr  = bus.in_instr;
  assign bus64.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  ty;
    logic        ill;
    logic [63:0] imm;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [63:0] pc;
  } stim_t;

  exp_t  sb[$];
  stim_t pend[$];
  int    total = 0;
  int    bad = 0;
  bit    armed = 1'b0;
  bit    gap = 1'b0;
  int    ordy_mode = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference decode computed from field weights in plain integer arithmetic
  function automatic exp_t model(logic [31:0] w, logic [63:0] pc);
    exp_t   e;
    longint v, s;
    s = w[31] ? 1 : 0;
    e.op = w[6:0]; e.rd = w[11:7]; e.f3 = w[14:12];
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f7 = w[31:25]; e.pc = pc;
    case (w[6:0])
      7'h33:                      e.ty = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: e.ty = 3'd1;
      7'h23:                      e.ty = 3'd2;
      7'h63:                      e.ty = 3'd3;
      7'h37, 7'h17:               e.ty = 3'd4;
      7'h6f:                      e.ty = 3'd5;
      default:                    e.ty = 3'd7;
    endcase
    case (e.ty)
      3'd1: v = longint'(w[30:20]) - s * 2048;
      3'd2: v = longint'(w[30:25]) * 32 + longint'(w[11:7]) - s * 2048;
      3'd3: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2 - s * 4096;
      3'd4: v = longint'(w[30:12]) * 4096 - s * (longint'(1) << 31);
      3'd5: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
                - s * (longint'(1) << 20);
      default: v = 0;
    endcase
    e.imm = v;
`ifdef DECODE_ILLEGAL_CHECK_EN
    e.ill = (w[1:0] != 2'b11) || (e.ty == 3'd7) || (w == 32'd0) ||
            ((e.ty == 3'd0) && (w[31:25] != 7'h00) && (w[31:25] != 7'h20));
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
    logic [31:0] w = $urandom;
    int          r = $urandom_range(0, 19);
    if (r < 15) w[6:0] = ops[$urandom_range(0, 9)];
    else if (r == 15) w = 32'd0;
    else if (r == 16) begin
      w[6:0] = 7'h33;
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  task automatic add(logic [31:0] w);
    stim_t s;
    s.w = w;
    s.pc = {$urandom, $urandom};
    pend.push_back(s);
  endtask

  task automatic drive();
    if (pend.size() != 0) begin
      bus.in_instr = pend[0].w;
      pc64 = pend[0].pc;
      bus.in_valid = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
    end else begin
      bus.in_valid = 1'b0;
    end
    bus.out_ready = (ordy_mode == 2) ? 1'($urandom_range(0, 1)) : (ordy_mode == 1);
  endtask

  // one clock: sample the handshake mid-cycle, record acceptance after the edge
  task automatic step();
    bit          acc, fl;
    logic [31:0] ci;
    logic [63:0] cp;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready && rst_n;
    fl = flush;
    ci = bus.in_instr;
    cp = pc64;
    @(posedge clk);
    #1;
    if (acc) begin
      if (!fl) sb.push_back(model(ci, cp));
      void'(pend.pop_front());
    end
  endtask

  task automatic run(int n);
    repeat (n) begin drive(); step(); end
  endtask

  task automatic drain();
    int n = 0;
    ordy_mode = 1;
    gap = 1'b0;
    while ((pend.size() != 0 || sb.size() != 0) && n < 200) begin
      drive(); step(); n++;
    end
    chk("drain_done", 64'(n < 200), 64'd1);
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid32", 64'(bus.out_valid), 64'd0);
    chk("async_rst_valid64", 64'(bus64.out_valid), 64'd0);
    sb.delete();
    run(2);
    rst_n = 1'b1;
  endtask

  // monitor: compare presented outputs against the scoreboard head
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'({bus.out_valid, bus64.out_valid}), 64'd0);
      chk("rst_fields", 64'({bus.out_opcode, bus.out_funct3, bus.out_funct7, bus.out_rd,
                             bus.out_rs1, bus.out_rs2, bus.out_type, bus.out_illegal}), 64'd0);
      chk("rst_imm_pc", 64'(bus.out_imm) | 64'(bus.out_pc) | bus64.out_imm | bus64.out_pc, 64'd0);
      armed = 1'b0;
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(armed && sb.size() < 2));
      chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
      chk("out_valid64", 64'(bus64.out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("fields", 64'({bus.out_opcode, bus.out_funct3, bus.out_funct7, bus.out_rd,
                           bus.out_rs1, bus.out_rs2, bus.out_type, bus.out_illegal}),
            64'({sb[0].op, sb[0].f3, sb[0].f7, sb[0].rd, sb[0].rs1, sb[0].rs2, sb[0].ty, sb[0].ill}));
        chk("imm32", 64'(bus.out_imm), 64'(sb[0].imm[31:0]));
        chk("pc32", 64'(bus.out_pc), 64'(sb[0].pc[31:0]));
        chk("imm64", bus64.out_imm, sb[0].imm);
        chk("pc64", bus64.out_pc, sb[0].pc);
        chk("type_ill64", 64'({bus64.out_type, bus64.out_illegal}), 64'({sb[0].ty, sb[0].ill}));
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) void'(sb.pop_front());
      if (flush) sb.delete();
      armed = 1'b1;
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.out_ready = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(2);

    // known encodings: add, addi -1, beq -4, lui 0x80000, all-zero, opcode 7F
    ordy_mode = 1;
    add(32'h003100B3); add(32'hFFF10093); add(32'hFE310EE3);
    add(32'h800000B7); add(32'h00000000); add(32'h0000007F);
    drain();

    // stall: A,B accepted, C waits, outputs hold A; then release in order
    ordy_mode = 0;
    add(32'h00A00093); add(32'h01400113); add(32'h01E00193);
    run(5);
    drain();

    // flush while FULL with a word offered
    ordy_mode = 0;
    add(rnd_word()); add(rnd_word()); add(rnd_word());
    run(3);
    flush = 1'b1; run(1); flush = 1'b0;
    run(1);
    // flush in HOLD with an accepted same-cycle word that must vanish
    add(rnd_word());
    flush = 1'b1; run(1); flush = 1'b0;
    drain();

    // flush coinciding with a delivered word
    ordy_mode = 1;
    add(rnd_word()); add(rnd_word());
    run(1);
    flush = 1'b1; run(1); flush = 1'b0;
    pend.delete();
    drain();

    // randomized traffic with backpressure, flushes and one mid-stream reset
    gap = 1'b1;
    ordy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if (pend.size() < 4) add(rnd_word());
      flush = ($urandom_range(0, 39) == 0);
      if (i == 700) begin
        flush = 1'b0;
        reset_mid();
      end
      run(1);
    end
    flush = 1'b0;
    drain();
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
